// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter and its picker.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: round-robin against the last winner,
// or fixed priority to requester 0 when rr_en is low.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic rr_en,
  output logic winner,
  output logic any
);

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    any    = req0 | req1;
    winner = M_CPU;
    if (req0 && req1) begin
      winner = rr_en ? ~last : M_CPU;
    end else if (req1) begin
      winner = M_AUX;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single DMEM port between the CPU data port (m0) and an
// auxiliary master (m1). Each access runs IDLE -> ISSUE -> RESP and ends
// with a one-cycle valid pulse to the granted master.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int RR_EN      = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_m0_req,
  input  logic                  i_m0_we,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [XLEN-1:0]       i_m0_wdata,
  output logic                  o_m0_valid,
  input  logic                  i_m1_req,
  input  logic                  i_m1_we,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [XLEN-1:0]       i_m1_wdata,
  output logic                  o_m1_valid,
  output logic [XLEN-1:0]       o_rdata,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [XLEN-1:0]       o_ram_wdata,
  input  logic [XLEN-1:0]       i_ram_q,
  output logic                  o_busy,
  output logic                  o_grant
);

  state_t                state;
  state_t                stateNext;
  logic                  winner;
  logic                  anyReq;
  logic                  lastGrant;
  logic                  grantReg;
  logic                  weReg;
  logic [ADDR_WIDTH-1:0] addrReg;
  logic [XLEN-1:0]       wdataReg;
  logic                  rrEn;

  assign rrEn = (RR_EN != 0);

  rr_pick2 uPick (
    .req0   (i_m0_req),
    .req1   (i_m1_req),
    .last   (lastGrant),
    .rr_en  (rrEn),
    .winner (winner),
    .any    (anyReq)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state: requests only matter in IDLE; ISSUE and RESP last one cycle each.
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:  if (anyReq) stateNext = ST_ISSUE;
      ST_ISSUE: stateNext = ST_RESP;
      ST_RESP:  stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  // Access registers: capture the winner in IDLE, advance the pointer in
  // ISSUE, and clear the RAM-facing fields so an idle port drives zeros.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addrReg   <= '0;
      wdataReg  <= '0;
      weReg     <= 1'b0;
      grantReg  <= M_CPU;
      lastGrant <= M_AUX;
    end else begin
      case (state)
        ST_IDLE: begin
          if (anyReq) begin
            grantReg <= winner;
            addrReg  <= (winner == M_AUX) ? i_m1_addr  : i_m0_addr;
            wdataReg <= (winner == M_AUX) ? i_m1_wdata : i_m0_wdata;
            weReg    <= (winner == M_AUX) ? i_m1_we    : i_m0_we;
          end
        end
        ST_ISSUE: lastGrant <= grantReg;
        ST_RESP: begin
          addrReg  <= '0;
          wdataReg <= '0;
          weReg    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_ram_we    = weReg && (state == ST_ISSUE);
  assign o_ram_addr  = addrReg;
  assign o_ram_wdata = wdataReg;
  assign o_rdata     = i_ram_q;
  assign o_busy      = (state != ST_IDLE);
  assign o_grant     = grantReg;
  assign o_m0_valid  = (state == ST_RESP) && (grantReg == M_CPU);
  assign o_m1_valid  = (state == ST_RESP) && (grantReg == M_AUX);

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port of the DualPortRam (DMEM) between two masters.
  - Master 0 is the CPU data port (load/store requests).
  - Master 1 is a secondary master, e.g. the planned UART loader or a debug port.
- Sequences each access as IDLE -> ISSUE -> RESP and returns a one-cycle valid pulse to the granted master.
- Replaces the ad-hoc memValid generation at SoC level. Sits between the masters and the DMEM instance.

Parameters:
- XLEN, 32, data width of both masters and the RAM.
- ADDR_WIDTH, 11, RAM address width; master addresses are truncated to this width.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, master 0 always wins.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_m0_req  in  1  master 0 request; held high until o_m0_valid
- i_m0_we  in  1  master 0 write (1) / read (0)
- i_m0_addr  in  ADDR_WIDTH  master 0 address
- i_m0_wdata  in  XLEN  master 0 write data
- o_m0_valid  out  1  one-cycle completion pulse to master 0
- i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, o_m1_valid: same as the m0 ports, for master 1
- o_rdata  out  XLEN  read data, equal to i_ram_q; meaningful only while a valid pulse is high
- o_ram_we  out  1  RAM write enable
- o_ram_addr  out  ADDR_WIDTH  RAM read/write address (drives both i_rAddr and i_wAddr)
- o_ram_wdata  out  XLEN  RAM write data
- i_ram_q  in  XLEN  RAM registered read data (1-cycle latency)
- o_busy  out  1  high in ISSUE and RESP
- o_grant  out  1  index of the currently or last granted master

Behaviour:
- Clock and reset are fixed: one clock, i_clk; i_rst is synchronous and active-high.

Reset:
- State = IDLE; o_m0_valid = o_m1_valid = o_ram_we = 0; o_busy = 0; o_grant = 0.
- o_ram_addr = 0 and o_ram_wdata = 0 (both registered); last-grant pointer = 1.
- o_rdata is not reset; it is a passthrough of i_ram_q.

IDLE:
- No request: stay in IDLE; all outputs are 0 except o_grant, which holds.
- Any request: pick the winner, register addr/wdata/we and o_grant = winner, go to ISSUE.
- Both masters requesting, RR_EN=1: the master not equal to the last-grant pointer wins. The first tie after reset goes to m0.
- Both masters requesting, RR_EN=0: m0 wins.

ISSUE (exactly 1 cycle):
- o_ram_addr and o_ram_wdata are driven from the registers.
- o_ram_we = latched we (high for exactly this cycle on writes).
- Last-grant pointer updates to the winner. Next state is RESP.

RESP (exactly 1 cycle):
- o_mX_valid = 1 for the granted master only; o_rdata = i_ram_q is the read result.
- Next state is IDLE. This gives a mandatory 1-cycle gap, so a master's held request is not re-granted on the same edge its valid is seen.

Timing and boundary conditions:
- Latency: request seen in cycle N -> valid in cycle N+2. Back-to-back throughput is 1 access per 3 cycles.
- A request withdrawn during ISSUE or RESP does not abort the access: the write still commits and valid still pulses.
- Request inputs are ignored outside IDLE. A new request in RESP is sampled in the next IDLE cycle.
- Reset during ISSUE: o_ram_we is deasserted from the next edge and no valid is produced. A write may have committed on the reset edge itself if ISSUE was active.
- Reset during RESP: the valid pulse is cut; the state returns to IDLE.
- Addresses wrap modulo 2^ADDR_WIDTH; no range check (decode happens upstream).
- Never more than one valid per cycle; never two grants in flight.

Decomposition:
- Shared package dmem_arb_pkg:
  - state encoding ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_RESP=2'd2;
  - master indices M_CPU=1'b0, M_AUX=1'b1.
- One sub-module, rr_pick2: a combinational two-way picker taking (req0, req1, last, rr_en) and returning (winner, any). It is reusable for future bus arbiters.

Test Plan:
- Single m0 read at addr 0x010 (RAM preloaded 0xDEADBEEF): req at cycle 0 -> o_m0_valid only at cycle 2, o_rdata=0xDEADBEEF, o_ram_we never high.
- m1 write addr 0x020 data 0x12345678, then m0 read of 0x020 -> o_ram_we high exactly 1 cycle; the read returns 0x12345678.
- Both requesting continuously for 6 accesses, RR_EN=1 -> grant order m0,m1,m0,m1,m0,m1; each valid 3 cycles apart.
- Same stimulus with RR_EN=0 -> all grants to m0; m1 is served only after m0 drops its request.
- Reset asserted during ISSUE of an m0 read -> no valid pulse, state IDLE next cycle, o_busy=0, the next tie goes to m0.
- m0 drops its request during ISSUE -> o_m0_valid still pulses in RESP; no second grant to m0.
